// File: rtl/vga_pkg.sv
// Shared VGA raster types and the default 640x480@60 timing (50 MHz clock, /2 divider).
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;
  localparam bit          VGA_H_SYNC_POL = 1'b0;
  localparam bit          VGA_V_SYNC_POL = 1'b0;
  localparam int unsigned VGA_PIX_DIV  = 2;
  localparam int unsigned VGA_COUNT_W  = 10;

  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
    logic        pol;
  } vga_axis_t;

  localparam vga_axis_t VGA_H_AXIS = '{active: VGA_H_ACTIVE, front: VGA_H_FRONT,
                                       sync: VGA_H_SYNC, back: VGA_H_BACK,
                                       pol: VGA_H_SYNC_POL};

  function automatic int unsigned axis_total(input vga_axis_t a);
    return a.active + a.front + a.sync + a.back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap flag and combinational sync/active decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter vga_axis_t   AXIS    = VGA_H_AXIS,
  parameter int unsigned COUNT_W = VGA_COUNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               step,
  output logic [COUNT_W-1:0] count,
  output logic               wrap,
  output logic               sync_lvl,
  output logic               active
);

  localparam int unsigned        TOTAL    = axis_total(AXIS);
  localparam logic [COUNT_W-1:0] LAST     = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] ACT_END  = COUNT_W'(AXIS.active);
  localparam logic [COUNT_W-1:0] SYNC_BEG = COUNT_W'(AXIS.active + AXIS.front);
  localparam logic [COUNT_W-1:0] SYNC_END = COUNT_W'(AXIS.active + AXIS.front + AXIS.sync);

  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign wrap   = (count_q == LAST);
  assign active = (count_q < ACT_END);
  // Half-open sync window gives exactly AXIS.sync units of assertion.
  assign sync_lvl = ((count_q >= SYNC_BEG) && (count_q < SYNC_END)) ? AXIS.pol : ~AXIS.pol;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, h/v counters and registered sync/position/strobe outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FRONT    = VGA_H_FRONT,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BACK     = VGA_H_BACK,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FRONT    = VGA_V_FRONT,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BACK     = VGA_V_BACK,
  parameter bit          H_SYNC_POL = VGA_H_SYNC_POL,
  parameter bit          V_SYNC_POL = VGA_V_SYNC_POL,
  parameter int unsigned PIX_DIV    = VGA_PIX_DIV,
  parameter int unsigned COUNT_W    = VGA_COUNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic               pix_tick,
  output logic               h_sync,
  output logic               v_sync,
  output logic               video_on,
  output logic [COUNT_W-1:0] x_loc,
  output logic [COUNT_W-1:0] y_loc,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam vga_axis_t H_AXIS = '{active: H_ACTIVE, front: H_FRONT, sync: H_SYNC,
                                   back: H_BACK, pol: H_SYNC_POL};
  localparam vga_axis_t V_AXIS = '{active: V_ACTIVE, front: V_FRONT, sync: V_SYNC,
                                   back: V_BACK, pol: V_SYNC_POL};

  if (PIX_DIV == 0 || H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_zero_param
    $error("vga_timing_gen: PIX_DIV and every width/porch must be nonzero");
  end
  if (64'(H_TOTAL) > (64'd1 << COUNT_W) || 64'(V_TOTAL) > (64'd1 << COUNT_W)) begin : g_width
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in COUNT_W bits");
  end

  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick;
  logic [COUNT_W-1:0] h_cnt, v_cnt;
  logic               h_wrap, v_wrap;
  logic               h_sync_lvl, v_sync_lvl, h_act, v_act;

  logic [COUNT_W-1:0] x_q, x_d, y_q, y_d;
  logic               hs_q, hs_d, vs_q, vs_d, video_q, video_d;
  logic               ls_q, ls_d, fs_q, fs_d;

  assign tick = enable && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  vga_axis_counter #(.AXIS(H_AXIS), .COUNT_W(COUNT_W)) u_h_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .step     (tick),
    .count    (h_cnt),
    .wrap     (h_wrap),
    .sync_lvl (h_sync_lvl),
    .active   (h_act)
  );

  vga_axis_counter #(.AXIS(V_AXIS), .COUNT_W(COUNT_W)) u_v_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .step     (tick && h_wrap),
    .count    (v_cnt),
    .wrap     (v_wrap),
    .sync_lvl (v_sync_lvl),
    .active   (v_act)
  );

  // Outputs capture the pre-increment position, so they trail the counters by one tick.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    video_d = video_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    if (tick) begin
      x_d     = h_cnt;
      y_d     = v_cnt;
      hs_d    = h_sync_lvl;
      vs_d    = v_sync_lvl;
      video_d = h_act && v_act;
      ls_d    = (h_cnt == '0);
      fs_d    = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= ~H_SYNC_POL;
      vs_q    <= ~V_SYNC_POL;
      video_q <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      video_q <= video_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign pix_tick    = tick;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign video_on    = video_q;
  assign x_loc       = x_q;
  assign y_loc       = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three configurations of vga_timing_gen checked every cycle against an enabled-cycle-count raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       en       [3];
  logic       tick_o   [3];
  logic       hs_o     [3];
  logic       vs_o     [3];
  logic       vid_o    [3];
  logic       ls_o     [3];
  logic       fs_o     [3];
  logic [9:0] x_o      [3];
  logic [9:0] y_o      [3];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
    int d;
  } cfg_t;

  typedef struct {
    bit tick, hs, vs, vid, ls, fs;
    int x, y;
  } exp_t;

  function automatic cfg_t get_cfg(input int i);
    cfg_t c;
    case (i)
      0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2};
      1:       c = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 1};
      default: c = '{20, 3, 5, 4, 12, 2, 3, 3, 1'b0, 1'b1, 3};
    endcase
    return c;
  endfunction

  // e = enabled clocks since reset; floor(e/d) pixels have been registered so far.
  function automatic exp_t model(input cfg_t c, input longint e, input bit pt, input bit enb);
    exp_t   m;
    longint t, p;
    int     h, v, ht, vt;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    t  = e / c.d;
    m.tick = enb && ((e % c.d) == longint'(c.d - 1));
    if (t == 0) begin
      m.x = 0; m.y = 0; m.vid = 1'b0; m.hs = ~c.hp; m.vs = ~c.vp; m.ls = 1'b0; m.fs = 1'b0;
    end else begin
      p = t - 1;
      h = int'(p % ht);
      v = int'((p / ht) % vt);
      m.x   = h;
      m.y   = v;
      m.vid = (h < c.ha) && (v < c.va);
      m.hs  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
      m.vs  = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
      m.ls  = pt && (h == 0);
      m.fs  = pt && (h == 0) && (v == 0);
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  vga_timing_gen dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en[0]), .pix_tick(tick_o[0]),
    .h_sync(hs_o[0]), .v_sync(vs_o[0]), .video_on(vid_o[0]), .x_loc(x_o[0]),
    .y_loc(y_o[0]), .line_start(ls_o[0]), .frame_start(fs_o[0])
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIX_DIV(1), .COUNT_W(10)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en[1]), .pix_tick(tick_o[1]),
    .h_sync(hs_o[1]), .v_sync(vs_o[1]), .video_on(vid_o[1]), .x_loc(x_o[1]),
    .y_loc(y_o[1]), .line_start(ls_o[1]), .frame_start(fs_o[1])
  );

  vga_timing_gen #(
    .H_ACTIVE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(3),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1), .PIX_DIV(3), .COUNT_W(10)
  ) dut_c (
    .clk(clk), .reset_n(reset_n), .enable(en[2]), .pix_tick(tick_o[2]),
    .h_sync(hs_o[2]), .v_sync(vs_o[2]), .video_on(vid_o[2]), .x_loc(x_o[2]),
    .y_loc(y_o[2]), .line_start(ls_o[2]), .frame_start(fs_o[2])
  );

  longint e_cnt [3];
  bit     pt    [3];
  bit     model_ok = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) model_ok <= 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        e_cnt[i] <= 0;
        pt[i]    <= 1'b0;
      end else begin
        pt[i] <= en[i] && ((e_cnt[i] % get_cfg(i).d) == longint'(get_cfg(i).d - 1));
        if (en[i]) e_cnt[i] <= e_cnt[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 3; i++) begin
        exp_t m;
        m = model(get_cfg(i), e_cnt[i], pt[i], en[i]);
        chk($sformatf("u%0d.pix_tick", i),    32'(tick_o[i]), int'(m.tick));
        chk($sformatf("u%0d.h_sync", i),      32'(hs_o[i]),   int'(m.hs));
        chk($sformatf("u%0d.v_sync", i),      32'(vs_o[i]),   int'(m.vs));
        chk($sformatf("u%0d.video_on", i),    32'(vid_o[i]),  int'(m.vid));
        chk($sformatf("u%0d.x_loc", i),       32'(x_o[i]),    m.x);
        chk($sformatf("u%0d.y_loc", i),       32'(y_o[i]),    m.y);
        chk($sformatf("u%0d.line_start", i),  32'(ls_o[i]),   int'(m.ls));
        chk($sformatf("u%0d.frame_start", i), 32'(fs_o[i]),   int'(m.fs));
      end
    end
  end

  initial begin
    int last_ls_a, last_fs_b;
    int a_lo_min, a_lo_max, b_hx_min, b_hx_max, b_vy_min, b_vy_max;
    bit found;

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) en[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.a.x_loc", 32'(x_o[0]), 0);
    chk("rst.a.video_on", 32'(vid_o[0]), 0);
    chk("rst.a.h_sync", 32'(hs_o[0]), 1);
    chk("rst.b.h_sync", 32'(hs_o[1]), 0);
    chk("rst.c.v_sync", 32'(vs_o[2]), 0);

    // Release: cycle 0 is the first clock with reset_n and enable high.
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) en[i] = 1'b1;
    @(negedge clk);
    chk("rel.cyc0.a.pix_tick", 32'(tick_o[0]), 0);
    chk("rel.cyc0.b.pix_tick", 32'(tick_o[1]), 1);
    @(negedge clk);
    chk("rel.cyc1.a.pix_tick", 32'(tick_o[0]), 1);
    chk("rel.cyc1.a.video_on", 32'(vid_o[0]), 0);
    @(negedge clk);
    chk("rel.cyc2.a.video_on", 32'(vid_o[0]), 1);
    chk("rel.cyc2.a.frame_start", 32'(fs_o[0]), 1);
    chk("rel.cyc2.a.line_start", 32'(ls_o[0]), 1);
    chk("rel.cyc2.a.xy", 32'({x_o[0], y_o[0]}), 0);

    last_ls_a = -1; last_fs_b = -1;
    a_lo_min = 9999; a_lo_max = -1;
    b_hx_min = 9999; b_hx_max = -1; b_vy_min = 9999; b_vy_max = -1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      en[2] = ($urandom_range(3) != 0);
      @(negedge clk);
      if (ls_o[0]) begin
        if (last_ls_a >= 0) chk("a.line_period", 32'(cyc - last_ls_a), 1600);
        last_ls_a = cyc;
      end
      if (fs_o[1]) begin
        if (last_fs_b >= 0) chk("b.frame_period", 32'(cyc - last_fs_b), 48);
        last_fs_b = cyc;
      end
      if (!hs_o[0] && y_o[0] == 10'd0) begin
        if (int'(x_o[0]) < a_lo_min) a_lo_min = int'(x_o[0]);
        if (int'(x_o[0]) > a_lo_max) a_lo_max = int'(x_o[0]);
      end
      if (hs_o[1]) begin
        if (int'(x_o[1]) < b_hx_min) b_hx_min = int'(x_o[1]);
        if (int'(x_o[1]) > b_hx_max) b_hx_max = int'(x_o[1]);
      end
      if (vs_o[1]) begin
        if (int'(y_o[1]) < b_vy_min) b_vy_min = int'(y_o[1]);
        if (int'(y_o[1]) > b_vy_max) b_vy_max = int'(y_o[1]);
      end
    end
    chk("a.hsync_first_x", 32'(a_lo_min), 656);
    chk("a.hsync_last_x", 32'(a_lo_max), 751);
    chk("b.hsync_first_x", 32'(b_hx_min), 5);
    chk("b.hsync_last_x", 32'(b_hx_max), 6);
    chk("b.vsync_first_y", 32'(b_vy_min), 4);
    chk("b.vsync_last_y", 32'(b_vy_max), 4);

    // Freeze A mid-line at x = 300.
    found = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (x_o[0] == 10'd300 && !tick_o[0]) found = 1'b1;
    end
    chk("a.reach_x300", 32'(found), 1);
    @(posedge clk); #1;
    en[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold.a.pix_tick", 32'(tick_o[0]), 0);
      chk("hold.a.x_loc", 32'(x_o[0]), 300);
      if (k < 9) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    en[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 5 && !found; k++) begin
      @(negedge clk);
      if (tick_o[0]) found = 1'b1;
    end
    chk("resume.a.tick_seen", 32'(found), 1);
    @(negedge clk);
    chk("resume.a.x_loc", 32'(x_o[0]), 301);

    // Random enables with occasional reset pulses.
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk); #1;
      en[0] = ($urandom_range(7) != 0);
      en[1] = ($urandom_range(3) != 0);
      en[2] = ($urandom_range(1) != 0);
      reset_n = ($urandom_range(799) != 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) en[i] = 1'b1;

    // Reset pulse on C mid-frame must replay the power-up sequence.
    found = 1'b0;
    for (int k = 0; k < 5000 && !found; k++) begin
      @(negedge clk);
      if (y_o[2] == 10'd5) found = 1'b1;
      @(posedge clk); #1;
    end
    chk("c.reach_y5", 32'(found), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rp.cyc0.c.xy", 32'({x_o[2], y_o[2]}), 0);
    chk("rp.cyc0.c.video_on", 32'(vid_o[2]), 0);
    chk("rp.cyc0.c.h_sync", 32'(hs_o[2]), 1);
    chk("rp.cyc0.c.v_sync", 32'(vs_o[2]), 0);
    chk("rp.cyc0.c.pix_tick", 32'(tick_o[2]), 0);
    @(negedge clk);
    @(negedge clk);
    chk("rp.cyc2.c.pix_tick", 32'(tick_o[2]), 1);
    chk("rp.cyc2.c.frame_start", 32'(fs_o[2]), 0);
    @(negedge clk);
    chk("rp.cyc3.c.frame_start", 32'(fs_o[2]), 1);
    chk("rp.cyc3.c.video_on", 32'(vid_o[2]), 1);
    chk("rp.cyc3.c.xy", 32'({x_o[2], y_o[2]}), 0);
    repeat (200) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, replacing the old combinational sync decoder that required externally supplied counters. It owns the pixel-clock divider and horizontal/vertical counters, and drives registered sync, blanking, coordinate and frame/line strobe outputs. It sits between the board clock and the snake renderer and VGA pins. Default parameters give 640x480@60 from a 50 MHz clock.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, asserted level of h_sync (0 = active-low)
- V_SYNC_POL, 0, asserted level of v_sync
- PIX_DIV, 2, clk cycles per pixel (>= 1)
- COUNT_W, 10, width of x_loc/y_loc and internal counters
- clk  in  1  system clock; the only clock
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  high: timing advances; low: everything freezes
- pix_tick  out  1  one-clk pulse; outputs below updated on the edge ending this cycle
- h_sync  out  1  horizontal sync, polarity per H_SYNC_POL
- v_sync  out  1  vertical sync, polarity per V_SYNC_POL
- video_on  out  1  high when registered position is inside the active area
- x_loc  out  COUNT_W  registered horizontal position
- y_loc  out  COUNT_W  registered vertical position
- line_start  out  1  one-clk pulse, first clk after outputs show x_loc = 0
- frame_start  out  1  one-clk pulse, first clk after outputs show (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Elaboration error if either exceeds 2^COUNT_W, or if PIX_DIV or any width/porch is 0.
- Divider div counts 0..PIX_DIV-1 while enable is high. pix_tick = enable && div == PIX_DIV-1. With PIX_DIV = 1, pix_tick = enable.
- On a pix_tick edge:
  - Outputs register the decode of the current (h, v).
  - h then increments. On wrap, H_TOTAL-1 goes to 0 and v increments.
  - v wraps V_TOTAL-1 to 0.
- Decode:
  - Horizontal sync is asserted for H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC. This is an exact width of H_SYNC pixels. The old decoder's extra pixel is removed.
  - Vertical sync uses the same rule on v. Both syncs sit at their negated level elsewhere.
  - video_on = h < H_ACTIVE && v < V_ACTIVE.
  - x_loc = h and y_loc = v, unmasked during blanking.
- line_start and frame_start fire in the clk after a pix_tick edge that registered h = 0 (and also v = 0 for frame_start). They are held low otherwise.
- enable low: div, h, v and all level outputs hold; pix_tick and the strobes are 0. Raising enable resumes from the held div value.

## Timing
- Reset values, one edge after reset_n sampled low:
  - div = h = v = 0
  - x_loc = y_loc = 0
  - video_on = 0, pix_tick = 0, line_start = 0, frame_start = 0
  - h_sync = ~H_SYNC_POL, v_sync = ~V_SYNC_POL
- Counting cycles from 0 as the first clk with reset_n high and enable high:
  - First pix_tick is in cycle PIX_DIV-1.
  - Outputs show (0,0) with video_on = 1 from cycle PIX_DIV.
  - line_start and frame_start pulse in cycle PIX_DIV.
- Output latency is one pix_tick behind the counters. All outputs are mutually aligned, and no output is combinational from the counters.
- Line period is H_TOTAL*PIX_DIV clks; frame period is V_TOTAL line periods.
- Reset mid-frame has priority over enable. The next frame restarts exactly as after power-up.
- At the simultaneous h and v wrap, the next registered position is (0,0), with line_start and frame_start both pulsing.

## Structure
- Package vga_pkg holds:
  - the default 640x480 timing constants;
  - a vga_axis_t struct (active, front, sync, back, pol), used for parameter passing.
- Sub-module vga_axis_counter:
  - parameters: one axis's timing, pol and COUNT_W;
  - inputs: clk, reset_n, step;
  - outputs: count, wrap, sync_lvl, active.
- Instantiate vga_axis_counter twice:
  - horizontal: step = pix_tick;
  - vertical: step = pix_tick && h_wrap.
- The top level holds the divider, the output registers and the strobes.

## Test plan
- Defaults, enable = 1:
  - pix_tick every 2 clks; line_start every 1600 clks; frame_start every 840000 clks.
  - h_sync is low only for x_loc 656..751, i.e. 96 ticks.
  - v_sync is low only for y_loc 490..491.
- Defaults, one full frame: video_on high for exactly 307200 ticks, with x_loc max 639 and y_loc max 479 while high.
- Reset release: first pix_tick in cycle 1; outputs (0,0), video_on = 1 and frame_start = 1 in cycle 2.
- Small config H = 4/1/2/1, V = 3/1/1/1, PIX_DIV = 1, both polarities 1:
  - h_sync high exactly at x = 5,6; v_sync high at y = 4;
  - frame length 48 clks.
- enable dropped for 10 clks mid-line at x = 300: all outputs hold and pix_tick = 0; x = 301 appears on the first tick after re-enable.
- reset_n pulsed low for one clk at y = 200: outputs go to reset values, and the (0,0) plus frame_start sequence repeats as after power-up.
